// File: rtl/urv_timer_cmp.sv
// urv_timer_cmp: system timer with a programmable prescaler, a 64-bit cycle
// counter, a tick counter and a set of one-shot/periodic compare channels.
module urv_timer_cmp #(
  parameter int unsigned g_timer_frequency = 1000,
  parameter int unsigned g_clock_frequency = 62500000,
  parameter int unsigned g_time_width      = 40,
  parameter int unsigned g_num_channels    = 2,
  parameter int unsigned g_presc_width     = 24
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wr_en_i,
  input  logic [7:0]                wr_addr_i,
  input  logic [63:0]               wr_data_i,
  output logic [g_time_width-1:0]   csr_time_o,
  output logic [63:0]               csr_cycles_o,
  output logic                      sys_tick_o,
  output logic [g_num_channels-1:0] irq_o
);

  localparam int unsigned TW        = g_time_width;
  localparam int unsigned PW        = g_presc_width;
  localparam int unsigned NCH       = g_num_channels;
  localparam int unsigned PRESC_RST = g_clock_frequency / g_timer_frequency - 1;

  // State
  logic [PW-1:0]  presc_q, presc_d;
  logic [PW-1:0]  presc_reload_q, presc_reload_d;
  logic           tick_q, tick_d;
  logic           run_q, run_d;
  logic [TW-1:0]  ticks_q, ticks_d;
  logic [63:0]    cycles_q, cycles_d;
  logic [TW-1:0]  cmp_q [NCH];
  logic [TW-1:0]  cmp_d [NCH];
  logic [TW-1:0]  period_q [NCH];
  logic [TW-1:0]  period_d [NCH];
  logic [NCH-1:0] en_q, en_d;
  logic [NCH-1:0] periodic_q, periodic_d;
  logic [NCH-1:0] pending_q, pending_d;

  // Decode / datapath helpers
  logic           wr_presc, wr_ctrl, wr_time, ch_space, clr, incr;
  logic [5:0]     ch_idx;
  logic [NCH-1:0] wr_cmp, wr_period, wr_cctrl, match;
  logic [TW-1:0]  ticks_inc;
  logic           wr_data_unused;

  // Bits above the register widths are intentionally dropped.
  assign wr_data_unused = ^wr_data_i;

  // Register write decode: channel k lives at 4+4k .. 6+4k.
  always_comb begin
    wr_presc  = wr_en_i && (wr_addr_i == 8'd0);
    wr_ctrl   = wr_en_i && (wr_addr_i == 8'd1);
    wr_time   = wr_en_i && (wr_addr_i == 8'd2);
    ch_space  = wr_en_i && (wr_addr_i[7:2] != 6'd0);
    ch_idx    = wr_addr_i[7:2] - 6'd1;
    wr_cmp    = '0;
    wr_period = '0;
    wr_cctrl  = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      if (ch_space && (ch_idx == 6'(k))) begin
        wr_cmp[k]    = (wr_addr_i[1:0] == 2'd0);
        wr_period[k] = (wr_addr_i[1:0] == 2'd1);
        wr_cctrl[k]  = (wr_addr_i[1:0] == 2'd2);
      end
    end
  end

  // Prescaler: free-running 0..PRESC, a reload write restarts it without a tick.
  always_comb begin
    presc_d        = presc_q + PW'(1);
    tick_d         = 1'b0;
    presc_reload_d = presc_reload_q;
    if (presc_q == presc_reload_q) begin
      presc_d = '0;
      tick_d  = 1'b1;
    end
    if (wr_presc) begin
      presc_d        = '0;
      tick_d         = 1'b0;
      presc_reload_d = wr_data_i[PW-1:0];
    end
  end

  // Cycle and tick counters: TIME write beats CLR beats increment.
  always_comb begin
    cycles_d  = cycles_q + 64'd1;
    clr       = wr_ctrl && wr_data_i[1];
    incr      = tick_q && run_q && !wr_time && !clr;
    ticks_inc = ticks_q + TW'(1);
    run_d     = wr_ctrl ? wr_data_i[0] : run_q;
    ticks_d   = ticks_q;
    if (wr_time) begin
      ticks_d = wr_data_i[TW-1:0];
    end else if (clr) begin
      ticks_d = '0;
    end else if (incr) begin
      ticks_d = ticks_inc;
    end
  end

  // Compare channels: match on increment, periodic re-arm, sticky pending.
  always_comb begin
    cmp_d      = cmp_q;
    period_d   = period_q;
    en_d       = en_q;
    periodic_d = periodic_q;
    pending_d  = pending_q;
    match      = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      // A CPU write to CMP overrides a coincident match entirely.
      match[k] = en_q[k] && incr && (ticks_inc == cmp_q[k]) && !wr_cmp[k];
      if (wr_cmp[k]) begin
        cmp_d[k] = wr_data_i[TW-1:0];
      end else if (match[k] && periodic_q[k] && (period_q[k] != '0)) begin
        cmp_d[k] = cmp_q[k] + period_q[k];
      end
      if (wr_period[k]) begin
        period_d[k] = wr_data_i[TW-1:0];
      end
      if (wr_cctrl[k]) begin
        en_d[k]       = wr_data_i[0];
        periodic_d[k] = wr_data_i[1];
      end
      if (match[k]) begin
        pending_d[k] = 1'b1;
      end else if (wr_cctrl[k] && wr_data_i[2]) begin
        pending_d[k] = 1'b0;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q        <= '0;
      presc_reload_q <= PW'(PRESC_RST);
      tick_q         <= 1'b0;
      run_q          <= 1'b1;
      ticks_q        <= '0;
      cycles_q       <= '0;
      for (int k = 0; k < int'(NCH); k++) begin
        cmp_q[k]    <= '1;
        period_q[k] <= '0;
      end
      en_q       <= '0;
      periodic_q <= '0;
      pending_q  <= '0;
    end else begin
      presc_q        <= presc_d;
      presc_reload_q <= presc_reload_d;
      tick_q         <= tick_d;
      run_q          <= run_d;
      ticks_q        <= ticks_d;
      cycles_q       <= cycles_d;
      cmp_q          <= cmp_d;
      period_q       <= period_d;
      en_q           <= en_d;
      periodic_q     <= periodic_d;
      pending_q      <= pending_d;
    end
  end

  assign csr_time_o   = ticks_q;
  assign csr_cycles_o = cycles_q;
  assign sys_tick_o   = tick_q;
  assign irq_o        = pending_q;

endmodule

// File: tb/tb_urv_timer_cmp.sv
// Bench for urv_timer_cmp: a 40-bit and an 8-bit instance share the stimulus
// and are each checked every cycle against an arithmetic model.
module tb_urv_timer_cmp;

  localparam int unsigned NCH = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        wr_en_i;
  logic [7:0]  wr_addr_i;
  logic [63:0] wr_data_i;

  logic [39:0] time40;
  logic [63:0] cyc40;
  logic        tick40;
  logic [1:0]  irq40;
  logic [7:0]  time8;
  logic [63:0] cyc8;
  logic        tick8;
  logic [1:0]  irq8;

  always #5 clk = ~clk;

  urv_timer_cmp #(.g_time_width(40), .g_num_channels(NCH)) u_dut40 (
    .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .csr_time_o(time40), .csr_cycles_o(cyc40),
    .sys_tick_o(tick40), .irq_o(irq40)
  );

  urv_timer_cmp #(.g_time_width(8), .g_num_channels(NCH)) u_dut8 (
    .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .csr_time_o(time8), .csr_cycles_o(cyc8),
    .sys_tick_o(tick8), .irq_o(irq8)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  // Model state, index 0 = 40-bit instance, 1 = 8-bit instance.
  // The prescaler is modelled as "cycles since the last restart".
  longint unsigned m_mask [2] = '{64'h0000_00FF_FFFF_FFFF, 64'h0000_0000_0000_00FF};
  longint unsigned m_ticks [2];
  longint unsigned m_cyc [2];
  longint unsigned m_base [2];
  longint unsigned m_reload [2];
  bit              m_run [2];
  longint unsigned m_cmp [2][NCH];
  longint unsigned m_per [2][NCH];
  bit              m_en [2][NCH];
  bit              m_pmode [2][NCH];
  bit              m_pend [2][NCH];
  bit              m_valid = 1'b0;

  function automatic bit m_tick(input int i);
    return (m_cyc[i] > m_base[i]) && (((m_cyc[i] - m_base[i]) % (m_reload[i] + 1)) == 0);
  endfunction

  task automatic model_step(input int i);
    bit tk, wt, clr, inc, wc, wp, wcc, mt;
    longint unsigned nt, d;
    if (rst_i) begin
      m_ticks[i] = 0; m_cyc[i] = 0; m_base[i] = 0; m_reload[i] = 62499; m_run[i] = 1'b1;
      for (int k = 0; k < int'(NCH); k++) begin
        m_cmp[i][k] = m_mask[i]; m_per[i][k] = 0;
        m_en[i][k] = 1'b0; m_pmode[i][k] = 1'b0; m_pend[i][k] = 1'b0;
      end
      return;
    end
    d   = wr_data_i;
    tk  = m_tick(i);
    wt  = wr_en_i && (wr_addr_i == 8'd2);
    clr = wr_en_i && (wr_addr_i == 8'd1) && d[1];
    inc = tk && m_run[i] && !wt && !clr;
    nt  = (m_ticks[i] + 1) & m_mask[i];
    for (int k = 0; k < int'(NCH); k++) begin
      wc  = wr_en_i && (wr_addr_i == 8'(4 + 4 * k));
      wp  = wr_en_i && (wr_addr_i == 8'(5 + 4 * k));
      wcc = wr_en_i && (wr_addr_i == 8'(6 + 4 * k));
      mt  = m_en[i][k] && inc && (nt == m_cmp[i][k]) && !wc;
      if (wc) m_cmp[i][k] = d & m_mask[i];
      else if (mt && m_pmode[i][k] && (m_per[i][k] != 0))
        m_cmp[i][k] = (m_cmp[i][k] + m_per[i][k]) & m_mask[i];
      if (mt) m_pend[i][k] = 1'b1;
      else if (wcc && d[2]) m_pend[i][k] = 1'b0;
      if (wp) m_per[i][k] = d & m_mask[i];
      if (wcc) begin m_en[i][k] = d[0]; m_pmode[i][k] = d[1]; end
    end
    if (wt) m_ticks[i] = d & m_mask[i];
    else if (clr) m_ticks[i] = 0;
    else if (inc) m_ticks[i] = nt;
    if (wr_en_i && (wr_addr_i == 8'd1)) m_run[i] = d[0];
    if (wr_en_i && (wr_addr_i == 8'd0)) begin
      m_reload[i] = d & 64'hFF_FFFF;
      m_base[i]   = m_cyc[i] + 1;
    end
    m_cyc[i] = m_cyc[i] + 1;
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    if (rst_i) m_valid = 1'b1;
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("time40", 64'(time40), m_ticks[0]);
      chk("cyc40", cyc40, m_cyc[0]);
      chk("tick40", 64'(tick40), 64'(m_tick(0)));
      chk("irq40", 64'(irq40), {62'd0, m_pend[0][1], m_pend[0][0]});
      chk("time8", 64'(time8), m_ticks[1]);
      chk("cyc8", cyc8, m_cyc[1]);
      chk("tick8", 64'(tick8), 64'(m_tick(1)));
      chk("irq8", 64'(irq8), {62'd0, m_pend[1][1], m_pend[1][0]});
    end
  end

  task automatic wr(input logic [7:0] a, input logic [63:0] d);
    wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
    @(negedge clk);
    wr_en_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_time(input int sel, input logic [63:0] t, input string name);
    int n = 0;
    logic [63:0] cur;
    cur = sel != 0 ? 64'(time8) : 64'(time40);
    while (cur != t && n < 200) begin
      @(negedge clk); n++;
      cur = sel != 0 ? 64'(time8) : 64'(time40);
    end
    if (cur != t) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout time %0h exp %0h", name, cur, t);
    end
  endtask

  task automatic wait_tick(input string name);
    int n = 0;
    while (!tick40 && n < 200) begin @(negedge clk); n++; end
    if (!tick40) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout tick got 0 exp 1", name);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_i = 1'b1; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_time", 64'(time40), 64'd0);
    chk("rst_cycles", cyc40, 64'd0);
    chk("rst_tick", 64'(tick40), 64'd0);
    chk("rst_irq", 64'(irq40), 64'd0);
    rst_i = 1'b0;

    // Prescaler 3: tick every 4 cycles.
    wr(8'd0, 64'd3);
    idle(4);
    chk("presc_tick1", 64'(tick40), 64'd1);
    chk("presc_time0", 64'(time40), 64'd0);
    idle(1);
    chk("presc_time1", 64'(time40), 64'd1);
    chk("presc_tick_low", 64'(tick40), 64'd0);
    idle(4);
    chk("presc_time2", 64'(time40), 64'd2);
    idle(4);
    chk("presc_time3", 64'(time40), 64'd3);
    chk("presc_cycles", cyc40, 64'd14);

    // One-shot channel 0 at 5.
    wr(8'd4, 64'd5);
    wr(8'd6, 64'd1);
    wait_time(0, 64'd4, "os_wait4");
    chk("os_irq_before", 64'(irq40[0]), 64'd0);
    wait_time(0, 64'd5, "os_wait5");
    chk("os_irq_set", 64'(irq40[0]), 64'd1);
    wr(8'd6, 64'd5);
    chk("os_irq_ack", 64'(irq40[0]), 64'd0);
    idle(16);
    chk("os_no_rearm", 64'(irq40[0]), 64'd0);
    wr(8'd6, 64'd0);

    // Periodic channel 1: 3, 7, 11.
    wr(8'd8, 64'd3);
    wr(8'd9, 64'd4);
    wr(8'd10, 64'd3);
    wr(8'd2, 64'd0);
    wait_time(0, 64'd3, "per_wait3");
    chk("per_irq3", 64'(irq40[1]), 64'd1);
    chk("per_cmp7", 64'(u_dut40.cmp_q[1]), 64'd7);
    wr(8'd10, 64'd7);
    chk("per_ack3", 64'(irq40[1]), 64'd0);
    wait_time(0, 64'd7, "per_wait7");
    chk("per_irq7", 64'(irq40[1]), 64'd1);
    chk("per_cmp11", 64'(u_dut40.cmp_q[1]), 64'd11);
    wr(8'd10, 64'd7);
    wait_time(0, 64'd11, "per_wait11");
    chk("per_irq11", 64'(irq40[1]), 64'd1);
    chk("per_cmp15", 64'(u_dut40.cmp_q[1]), 64'd15);
    wr(8'd10, 64'd4);

    // Wrap-around match (8-bit sees 0xFE, 40-bit sees 2^40-2).
    wr(8'd4, 64'd1);
    wr(8'd6, 64'd1);
    wr(8'd2, 64'hFF_FFFF_FFFE);
    wait_time(1, 64'd1, "wrap_wait");
    chk("wrap_irq8", 64'(irq8[0]), 64'd1);
    chk("wrap_irq40", 64'(irq40[0]), 64'd1);
    chk("wrap_time40", 64'(time40), 64'd1);
    wr(8'd6, 64'd4);

    // Periodic re-arm across the wrap.
    wr(8'd8, 64'hFF_FFFF_FFFE);
    wr(8'd9, 64'd4);
    wr(8'd10, 64'd3);
    wr(8'd2, 64'hFF_FFFF_FFFC);
    wait_time(1, 64'hFE, "pwrap_wait");
    chk("pwrap_irq8", 64'(irq8[1]), 64'd1);
    chk("pwrap_cmp8", 64'(u_dut8.cmp_q[1]), 64'd2);
    chk("pwrap_cmp40", 64'(u_dut40.cmp_q[1]), 64'd2);
    wr(8'd10, 64'd4);

    // CLR with RUN=0, then idle, then resume.
    wr(8'd1, 64'd2);
    chk("clr_time", 64'(time40), 64'd0);
    idle(10);
    chk("stopped_time", 64'(time40), 64'd0);
    wr(8'd1, 64'd1);

    // Unmapped and out-of-range channel writes must be ignored.
    wr(8'd3, 64'h55);
    wr(8'd7, 64'h7);
    wr(8'd12, 64'd0);
    wr(8'd14, 64'd7);
    wr(8'd255, 64'h7);

    // ACK coincident with a match: set wins.
    wr(8'd2, 64'h20);
    wr(8'd4, 64'h22);
    wr(8'd6, 64'd1);
    wait_time(0, 64'h21, "ackm_wait");
    wait_tick("ackm_tick");
    wr(8'd6, 64'd5);
    chk("ackm_time", 64'(time40), 64'h22);
    chk("ackm_irq", 64'(irq40[0]), 64'd1);
    wr(8'd6, 64'd4);
    chk("ackm_clear", 64'(irq40[0]), 64'd0);

    // CMP write coincident with a match: write wins, no pending.
    wr(8'd4, 64'h24);
    wr(8'd6, 64'd1);
    wait_time(0, 64'h23, "cmpw_wait");
    wait_tick("cmpw_tick");
    wr(8'd4, 64'h30);
    chk("cmpw_time", 64'(time40), 64'h24);
    chk("cmpw_irq", 64'(irq40[0]), 64'd0);
    chk("cmpw_cmp", 64'(u_dut40.cmp_q[0]), 64'h30);
    wr(8'd6, 64'd0);

    // TIME write coincident with a tick: TIME wins.
    wait_tick("timew_tick");
    wr(8'd2, 64'h100);
    chk("timew_time40", 64'(time40), 64'h100);
    chk("timew_time8", 64'(time8), 64'h00);

    // Mid-run reset with pending set.
    wr(8'd2, 64'd0);
    wr(8'd4, 64'd1);
    wr(8'd6, 64'd1);
    wait_time(0, 64'd1, "mrst_wait");
    chk("mrst_irq_before", 64'(irq40[0]), 64'd1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("mrst_time", 64'(time40), 64'd0);
    chk("mrst_cycles", cyc40, 64'd0);
    chk("mrst_tick", 64'(tick40), 64'd0);
    chk("mrst_irq", 64'(irq40), 64'd0);
    n = 0;
    while (!tick40 && n < 70000) begin @(negedge clk); n++; end
    chk("mrst_first_tick", 64'(tick40), 64'd1);
    chk("mrst_tick_cycle", cyc40, 64'd62500);
    chk("mrst_tick8", 64'(tick8), 64'd1);
    @(negedge clk);
    chk("mrst_time_after", 64'(time40), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
